// File: rtl/axis_i2c_rx_packer_if.sv
// AXI-Stream word channel between the I2C read-byte packer and its consumer.
// Latency: none, wires only.
// Backpressure: tready from the slave side stalls the master, which holds its payload stable.
// Signals: tdata/tkeep/tlast/tvalid driven by master, tready driven by slave.
interface axis_i2c_rx_packer_if #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_i2c_rx_packer.sv
// Packs strobed I2C read bytes little-endian into AXIS words, framed by flush/idle timeout.
// Latency: word pushed into an empty FIFO at edge N shows tvalid after edge N+1.
// Backpressure: words queue in a FIFO_DEPTH buffer; a push into a full buffer is dropped and flagged sticky.
// Ports: clk_i/rst_i (sync, active-high); rdata_i/rvalid_i byte input; flush_i closes the packet;
//        clr_ovf_i clears overflow_o; m_axis word output; fifo_level_o words held.
module axis_i2c_rx_packer #(
    parameter int BYTE_WIDTH     = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [BYTE_WIDTH-1:0]         rdata_i,
    input  logic                          rvalid_i,
    input  logic                          flush_i,
    input  logic                          clr_ovf_i,
    axis_i2c_rx_packer_if.master          m_axis,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o
);
    localparam int DATA_W = BYTE_WIDTH * BYTES_PER_WORD;
    localparam int CNT_W  = $clog2(BYTES_PER_WORD + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef struct packed {
        logic [DATA_W-1:0]         data;
        logic [BYTES_PER_WORD-1:0] keep;
        logic                      last;
    } word_t;

    // ---------------- packer ----------------
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_sum;
    logic [DATA_W-1:0] asm_q;
    logic [DATA_W-1:0] asm_sum;
    logic [TMO_W-1:0]  tmo;
    logic              word_full;
    logic              tmo_hit;
    logic              flush_req;
    logic              push;
    word_t             push_word;

    always_comb begin
        asm_sum = asm_q;
        if (rvalid_i) begin
            asm_sum[cnt*BYTE_WIDTH +: BYTE_WIDTH] = rdata_i;
        end
        cnt_sum   = cnt + CNT_W'(rvalid_i);
        word_full = (cnt_sum == CNT_W'(BYTES_PER_WORD));
        // A byte arriving this cycle means the link is not idle, so it beats the timeout.
        tmo_hit   = TMO_EN && (cnt != '0) && !rvalid_i && (tmo == TMO_LAST);
        flush_req = flush_i | tmo_hit;
        // The incoming byte is merged first, so flush sees cnt_sum rather than cnt.
        push      = word_full | (flush_req & (cnt_sum != '0));

        push_word.data = asm_sum;   // unused lanes are already zero: asm_q clears on every push
        push_word.last = flush_req;
        push_word.keep = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            push_word.keep[i] = (i < int'(cnt_sum));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt   <= '0;
            asm_q <= '0;
            tmo   <= '0;
        end else begin
            if (push) begin
                cnt   <= '0;
                asm_q <= '0;
            end else begin
                cnt   <= cnt_sum;
                asm_q <= asm_sum;
            end
            if (push || rvalid_i || (cnt == '0) || !TMO_EN) begin
                tmo <= '0;
            end else begin
                tmo <= tmo + 1'b1;
            end
        end
    end

    // ---------------- word FIFO + registered head ----------------
    word_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    word_t             out_q;
    logic              out_vld;
    logic              fifo_full;
    logic              pop;
    logic              wr_en;
    logic              ovf_set;
    logic [LVL_W-1:0]  remain;
    logic [PTR_W-1:0]  head_idx;

    // level counts every stored word, including the one currently shown on m_axis.
    assign fifo_full = (level == LVL_W'(FIFO_DEPTH));
    assign pop       = out_vld & m_axis.tready;
    assign wr_en     = push & (~fifo_full | pop);
    assign ovf_set   = push & fifo_full & ~pop;
    // The head register looks only at words stored before this edge, which gives
    // the one-cycle presentation latency and avoids a combinational push->tvalid path.
    assign remain    = level - LVL_W'(pop);
    assign head_idx  = rd_ptr + PTR_W'(pop);

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow_o <= 1'b0;
            out_vld    <= 1'b0;
            out_q      <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PTR_W'(wr_en);
            rd_ptr     <= rd_ptr + PTR_W'(pop);
            level      <= level + LVL_W'(wr_en) - LVL_W'(pop);
            overflow_o <= ovf_set | (overflow_o & ~clr_ovf_i);
            if (!out_vld || pop) begin
                if (remain != '0) begin
                    out_vld <= 1'b1;
                    out_q   <= mem[head_idx];
                end else begin
                    out_vld <= 1'b0;
                    out_q   <= '0;
                end
            end
        end
    end

    assign m_axis.tvalid = out_vld;
    assign m_axis.tdata  = out_q.data;
    assign m_axis.tkeep  = out_q.keep;
    assign m_axis.tlast  = out_q.last;
    assign fifo_level_o  = level;
endmodule
